hamming_secded_pipe: RTL

Pipelined, parametrised SECDED Hamming decoder. It is the streaming successor to the 64-bit combinational single-error-correcting decoder. It takes extended Hamming codewords (Hamming plus overall parity) over a valid/ready stream, corrects single-bit errors, and flags double-bit errors. It also keeps saturating error counters for the memory/link scrubber above it.

---
 rtl/hamming_pkg.sv | 38 +++
 rtl/hamming_syndrome.sv | 24 ++
 rtl/hamming_secded_pipe.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/hamming_pkg.sv
// Shared definitions for the SECDED Hamming decoder family: status codes and
// elaboration-time helpers describing the extended-Hamming codeword layout.
package hamming_pkg;

  typedef enum logic [1:0] {
    ST_CLEAN  = 2'b00,
    ST_CORR   = 2'b01,
    ST_UNCORR = 2'b10
  } status_e;

  // Smallest r with 2^r >= data_w + r + 1.
  function automatic int calc_parity_w(input int data_w);
    int r;
    r = 0;
    while ((1 << r) < data_w + r + 1) r++;
    return r;
  endfunction

  // True for Hamming positions 1, 2, 4, 8, ... (check-bit positions).
  function automatic bit is_pow2(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Hamming position holding payload bit k: the k-th non-power-of-two
  // position counting upward from 3.
  function automatic int data_pos(input int k);
    int pos;
    int seen;
    pos  = 2;
    seen = -1;
    while (seen < k) begin
      pos++;
      if (!is_pow2(pos)) seen++;
    end
    return pos;
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome / overall-parity generator for an extended Hamming
// codeword. Bit 0 is the overall parity bit; bits 1..CODE_W-1 are Hamming
// positions. Shared with the encoder-side checker.
module hamming_syndrome #(
  parameter int CODE_W   = 72,
  parameter int PARITY_W = $clog2(CODE_W)
) (
  input  logic [CODE_W-1:0]   code_i,
  output logic [PARITY_W-1:0] syndrome_o,
  output logic                parity_o
);

  // Syndrome is the XOR of the indices of every set position; p is the XOR of all bits.
  always_comb begin
    // NOTE: every combinational output is given a default before any
    // conditional update so no latch can be inferred.
    syndrome_o = '0;
    for (int i = 1; i < CODE_W; i++) begin
      if (code_i[i]) syndrome_o = syndrome_o ^ PARITY_W'(i);
    end
    parity_o = ^code_i;
  end

endmodule

// File: rtl/hamming_secded_pipe.sv
// Two-stage pipelined SECDED decoder on a valid/ready stream.
//   S1: codeword, enable, syndrome and overall parity.
//   S2: decoded payload, status and syndrome (the output register).
// Saturating corrected/uncorrectable counters advance on output handshakes.
module hamming_secded_pipe
  import hamming_pkg::*;
#(
  parameter int  DATA_W   = 64,
  parameter int  COUNT_W  = 16,
  localparam int PARITY_W = calc_parity_w(DATA_W),
  localparam int CODE_W   = DATA_W + PARITY_W + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CODE_W-1:0]   code_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   data_out,
  output logic [1:0]          status,
  output logic [PARITY_W-1:0] syndrome,
  input  logic                count_clr,
  output logic [COUNT_W-1:0]  corr_count,
  output logic [COUNT_W-1:0]  uncorr_count
);

  // Stage 1 state
  logic                s1_valid_q;
  logic [CODE_W-1:0]   s1_code_q;
  logic [PARITY_W-1:0] s1_syn_q;
  logic                s1_par_q;
  logic                s1_en_q;

  // Stage 2 state
  logic                s2_valid_q;
  logic [DATA_W-1:0]   s2_data_q;
  status_e             s2_status_q;
  logic [PARITY_W-1:0] s2_syn_q;

  // Error counters
  logic [COUNT_W-1:0]  corr_q;
  logic [COUNT_W-1:0]  uncorr_q;

  // Syndrome of the incoming word, registered into S1
  logic [PARITY_W-1:0] in_syn;
  logic                in_par;

  hamming_syndrome #(
    .CODE_W   (CODE_W),
    .PARITY_W (PARITY_W)
  ) u_syndrome (
    .code_i     (code_in),
    .syndrome_o (in_syn),
    .parity_o   (in_par)
  );

  // Flow control: S2 advances when empty or drained; S1 advances with in_ready.
  logic s2_advance;
  logic out_fire;

  assign s2_advance = !s2_valid_q || out_ready;
  assign in_ready   = !s1_valid_q || !s2_valid_q || out_ready;
  assign out_fire   = s2_valid_q && out_ready;

  // S1 capture: load a new word (or a bubble) whenever the pipe can move.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples pre-edge values and the pipeline shifts as one.
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_code_q  <= '0;
      s1_syn_q   <= '0;
      s1_par_q   <= 1'b0;
      s1_en_q    <= 1'b0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_code_q <= code_in;
        s1_syn_q  <= in_syn;
        s1_par_q  <= in_par;
        s1_en_q   <= enable;
      end
    end
  end

  // Decode of the S1 word: classify, optionally flip the faulty bit.
  logic              syn_nz;
  logic              syn_in_range;
  logic              do_flip;
  logic [CODE_W-1:0] fixed_code;
  logic [DATA_W-1:0] data_d;
  status_e           status_d;

  always_comb begin
    syn_nz       = |s1_syn_q;
    syn_in_range = int'(s1_syn_q) < CODE_W;
    do_flip      = syn_nz && s1_par_q && syn_in_range && s1_en_q;
    fixed_code   = s1_code_q ^ (CODE_W'(do_flip) << s1_syn_q);
    if (!syn_nz) begin
      // Error confined to the overall parity bit leaves the payload intact.
      status_d = s1_par_q ? ST_CORR : ST_CLEAN;
    end else if (s1_par_q && syn_in_range) begin
      status_d = ST_CORR;
    end else begin
      status_d = ST_UNCORR;
    end
  end

  // Payload bits sit at the non-power-of-two positions, ascending from 3.
  for (genvar k = 0; k < DATA_W; k++) begin : g_extract
    assign data_d[k] = fixed_code[data_pos(k)];
  end

  // S2 capture: holds while the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      s2_status_q <= ST_CLEAN;
      s2_syn_q    <= '0;
    end else if (s2_advance) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_data_q   <= data_d;
        s2_status_q <= status_d;
        s2_syn_q    <= s1_syn_q;
      end
    end
  end

  // Saturating error counters; a clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_q   <= '0;
      uncorr_q <= '0;
    end else if (count_clr) begin
      corr_q   <= '0;
      uncorr_q <= '0;
    end else if (out_fire) begin
      if (s2_status_q == ST_CORR && corr_q != '1) begin
        corr_q <= corr_q + COUNT_W'(1);
      end
      if (s2_status_q == ST_UNCORR && uncorr_q != '1) begin
        uncorr_q <= uncorr_q + COUNT_W'(1);
      end
    end
  end

  assign out_valid    = s2_valid_q;
  assign data_out     = s2_data_q;
  assign status       = s2_status_q;
  assign syndrome     = s2_syn_q;
  assign corr_count   = corr_q;
  assign uncorr_count = uncorr_q;

endmodule
